// File: rtl/bitserial_word_adapter.sv
// Word-level front/back end for a bit-serial adder.
// Accepts an operand pair, clears the adder, streams both operands LSB-first,
// gathers the serial sum (one cycle behind the inputs) and presents sum/cout.
module bitserial_word_adapter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] op_a,
  input  logic [W-1:0] op_b,
  output logic         ser_clr,
  output logic         ser_a,
  output logic         ser_b,
  input  logic         ser_q,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
  output logic         cout
);

  localparam int CW = $clog2(W + 2);
  localparam logic [CW-1:0] CNT_LAST = CW'(W + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CLR  = 2'd1,
    S_RUN  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [W:0]    a_sh_q, b_sh_q;
  logic [W:0]    res_q;
  logic          in_ready_q, ser_clr_q, out_valid_q;

  logic [W:0]    a_sh_d, b_sh_d, res_d;
  logic [CW-1:0] cnt_d;

  // Zero-filled right shifts, result shifted in from the top, counter increment
  assign a_sh_d = {1'b0, a_sh_q[W:1]};
  assign b_sh_d = {1'b0, b_sh_q[W:1]};
  assign res_d  = {ser_q, res_q[W:1]};
  assign cnt_d  = cnt_q + CW'(1);

  // Control FSM with registered handshake/clear outputs and the datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      res_q       <= '0;
      in_ready_q  <= 1'b1;
      ser_clr_q   <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid && in_ready_q) begin
            a_sh_q     <= {1'b0, op_a};
            b_sh_q     <= {1'b0, op_b};
            in_ready_q <= 1'b0;
            state_q    <= S_CLR;
          end
        end
        S_CLR: begin
          // Adder has seen clear for at least this edge, so carry starts at 0
          cnt_q     <= '0;
          ser_clr_q <= 1'b0;
          state_q   <= S_RUN;
        end
        S_RUN: begin
          a_sh_q <= a_sh_d;
          b_sh_q <= b_sh_d;
          // q lags the inputs by one cycle, so nothing valid arrives while cnt==0
          if (cnt_q != '0) begin
            res_q <= res_d;
          end
          if (cnt_q == CNT_LAST) begin
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
          end else begin
            cnt_q <= cnt_d;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            ser_clr_q   <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          cnt_q       <= '0;
          in_ready_q  <= 1'b1;
          ser_clr_q   <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Serial bits only reach the adder while running; shift regs are loaded earlier
  assign ser_a     = (state_q == S_RUN) & a_sh_q[0];
  assign ser_b     = (state_q == S_RUN) & b_sh_q[0];
  assign in_ready  = in_ready_q;
  assign ser_clr   = ser_clr_q;
  assign out_valid = out_valid_q;
  assign sum       = res_q[W-1:0];
  assign cout      = res_q[W];

endmodule

// File: tb/tb_bitserial_word_adapter.sv
// Bench for bitserial_word_adapter: includes a serial adder model, a
// transaction-level reference (cycles since accept, integer addition) and
// per-cycle output checking plus directed literal cases and random words.
module tb_bitserial_word_adapter;

  localparam int W = 8;

  logic         clk;
  logic         reset;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] op_a, op_b;
  logic         ser_clr, ser_a, ser_b, ser_q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;

  int n_assert = 0;
  int n_fail   = 0;

  bitserial_word_adapter #(.W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op_a      (op_a),
    .op_b      (op_b),
    .ser_clr   (ser_clr),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_q     (ser_q),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-serial adder: synchronous clear, registered sum bit, internal carry
  logic add_c;
  always @(posedge clk) begin
    if (ser_clr) begin
      add_c <= 1'b0;
      ser_q <= 1'b0;
    end else begin
      ser_q <= ser_a ^ ser_b ^ add_c;
      add_c <= (ser_a & ser_b) | (ser_a & add_c) | (ser_b & add_c);
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: idle, or busy with m_k = cycles since the accept edge
  // (1 = clear cycle, 2..W+3 = streaming cycles), then done until out_ready.
  bit           m_busy = 1'b0;
  bit           m_done = 1'b0;
  int           m_k = 0;
  logic [W-1:0] m_a = '0, m_b = '0;
  int           cyc = 0;
  int           acc_cyc = 0;
  int           lat = -1;
  logic         prev_ov = 1'b0;
  logic [W-1:0] cap_a = '0, cap_b = '0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_busy = 1'b0;
      m_done = 1'b0;
      m_k    = 0;
    end else begin
      cyc++;
      if (!m_busy) begin
        if (in_valid) begin
          m_busy  = 1'b1;
          m_done  = 1'b0;
          m_k     = 1;
          m_a     = op_a;
          m_b     = op_b;
          acc_cyc = cyc;
        end
      end else if (m_done) begin
        if (out_ready) begin
          m_busy = 1'b0;
          m_done = 1'b0;
        end
      end else if (m_k == W + 3) begin
        m_done = 1'b1;
      end else begin
        m_k++;
      end
    end
  end

  // Per-cycle comparison against the reference, sampled mid-cycle
  always @(negedge clk) begin
    logic       e_ir, e_clr, e_ov, e_sa, e_sb;
    logic [W:0] e_res;
    e_ir  = !m_busy;
    e_clr = !m_busy || (!m_done && m_k == 1);
    e_ov  = m_busy && m_done;
    e_sa  = 1'b0;
    e_sb  = 1'b0;
    if (m_busy && !m_done && m_k >= 2 && m_k < 2 + W) begin
      e_sa = m_a[m_k-2];
      e_sb = m_b[m_k-2];
      cap_a[m_k-2] = ser_a;
      cap_b[m_k-2] = ser_b;
    end
    chk("in_ready", 32'(in_ready), 32'(e_ir));
    chk("ser_clr", 32'(ser_clr), 32'(e_clr));
    chk("out_valid", 32'(out_valid), 32'(e_ov));
    chk("ser_a", 32'(ser_a), 32'(e_sa));
    chk("ser_b", 32'(ser_b), 32'(e_sb));
    if (e_ov) begin
      e_res = {1'b0, m_a} + {1'b0, m_b};
      chk("sum_model", 32'({cout, sum}), 32'(e_res));
    end
    if (out_valid === 1'b1 && prev_ov !== 1'b1) lat = cyc - acc_cyc;
    prev_ov = out_valid;
  end

  // One word: wait for in_ready, present the pair, wait for out_valid,
  // optionally stall out_ready (with ignored in_valid noise), then release.
  task automatic run_word(input logic [W-1:0] a, input logic [W-1:0] b,
                          input int hold, input bit noise);
    logic [W:0] lit;
    bit         seen;
    int         guard;
    lit   = {1'b0, a} + {1'b0, b};
    guard = 0;
    while (in_ready !== 1'b1 && guard < 50) begin
      @(posedge clk); #2;
      guard++;
    end
    chk("in_ready_wait", 32'(guard < 50), 32'd1);
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #2;
    in_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk); #2;
      end
    end
    chk("out_valid_timeout", 32'(seen), 32'd1);
    chk("sum_lit", 32'({cout, sum}), 32'(lit));
    for (int i = 0; i < hold; i++) begin
      if (noise) begin
        in_valid = 1'b1;
        op_a     = W'($urandom);
        op_b     = W'($urandom);
      end
      @(posedge clk); #2;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    $display("word a=%02h b=%02h -> sum=%02h cout=%0b hold=%0d", a, b, sum, cout, hold);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op_a      = '0;
    op_b      = '0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_ser_clr", 32'(ser_clr), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'({cout, sum}), 32'd0);
    chk("rst_ser_ab", 32'({ser_a, ser_b}), 32'd0);
    @(posedge clk); #2;
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;

    // 1: basic add, latency from accept edge to out_valid rise
    lat = -1;
    run_word(8'h5A, 8'h3C, 0, 1'b0);
    chk("t1_sum", 32'({cout, sum}), 32'h096);
    chk("t1_latency", 32'(lat), 32'd11);

    // 2: carry out of the top bit
    run_word(8'hFF, 8'h01, 0, 1'b0);
    chk("t2_sum", 32'({cout, sum}), 32'h100);

    // 3: back-to-back, no carry leak between words
    run_word(8'hFF, 8'hFF, 0, 1'b0);
    chk("t3a_sum", 32'({cout, sum}), 32'h1FE);
    run_word(8'h00, 8'h00, 0, 1'b0);
    chk("t3b_sum", 32'({cout, sum}), 32'h000);

    // 4: output stall with ignored input traffic
    run_word(8'h12, 8'h34, 5, 1'b1);
    chk("t4_sum", 32'({cout, sum}), 32'h046);

    // 5: reset in the middle of streaming (cnt==4)
    op_a     = 8'h77;
    op_b     = 8'h66;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    chk("t5_ser_clr", 32'(ser_clr), 32'd1);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    reset = 1'b0;
    @(posedge clk); #2;
    run_word(8'h01, 8'h01, 0, 1'b0);
    chk("t5_sum", 32'({cout, sum}), 32'h002);

    // 6: serial bit order
    run_word(8'hA5, 8'h0F, 1, 1'b0);
    chk("t6_sum", 32'({cout, sum}), 32'h0B4);
    chk("t6_ser_a_bits", 32'(cap_a), 32'hA5);
    chk("t6_ser_b_bits", 32'(cap_b), 32'h0F);

    // Random words with random stalls, gaps and input noise
    for (int n = 0; n < 40; n++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom);
      rb = W'($urandom);
      repeat ($urandom_range(0, 3)) begin
        @(posedge clk); #2;
      end
      run_word(ra, rb, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
